game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Parametrised game-flow controller for the board-game top level. It generalises the fixed MENU/PLAY/SETTLE sequencer in four ways: a PAUSE state, N players with turn rotation, a per-turn countdown clock with a selectable timeout policy, and sound-event requests for the music block. It sits between the keyboard/selector pulses and the play, GFX and MUSIC blocks, all on the system clock domain.

## Interface
- CLK_HZ, 100_000_000: clk frequency; sets the 1 s prescaler.
- N_PLAYERS, 2: number of players; legal range 2..8.
- TURN_SEC, 30: seconds per turn; legal range 1..255.
- WARN_SEC, 5: remaining-seconds value that triggers the warning sound; 0 disables; must be < TURN_SEC.
- TIMEOUT_MODE, 0: 0 = skip the turn on timeout, 1 = forfeit on timeout.
- PW: localparam = max(1, clog2(N_PLAYERS)).
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- key_confirm  in  1  one-cycle pulse (confirm key / selector press).
- key_pause  in  1  one-cycle pulse (pause key).
- move_done  in  1  one-cycle pulse: play block committed a legal move.
- game_over  in  1  one-cycle pulse: play block detected end of game.
- winner_in  in  PW  winner index, valid while game_over = 1.
- state  out  2  00 MENU, 01 PLAY, 10 PAUSE, 11 SETTLE.
- current_player  out  PW  index of the player to move.
- turn_sec_left  out  8  seconds remaining in the current turn.
- winner  out  PW  latched winner; valid in SETTLE.
- board_clear  out  1  one-cycle pulse on MENU→PLAY.
- timeout  out  1  one-cycle pulse when a turn expires.
- sound_req  out  1  one-cycle pulse.
- sound_code  out  3  1 start, 2 move, 3 timeout, 4 game end, 5 warning; holds its last value between requests.

## Operation
- Reset values: state = MENU, current_player = 0, turn_sec_left = TURN_SEC, winner = 0, board_clear = 0, timeout = 0, sound_req = 0, sound_code = 0, prescaler = 0.
- The prescaler counts 0..CLK_HZ-1 only in PLAY. Its wrap produces an internal tick. It is frozen in MENU, PAUSE and SETTLE, and cleared on every turn reload.
- MENU:
  - key_confirm → PLAY.
  - Same edge: current_player = 0, turn_sec_left = TURN_SEC, prescaler = 0, board_clear pulse, sound code 1.
- PLAY, with priority high to low:
  1. game_over → SETTLE; winner = winner_in; sound code 4.
  2. key_pause → PAUSE; all counters hold.
  3. move_done → current_player advances (N_PLAYERS-1 wraps to 0); reload turn_sec_left and prescaler; sound code 2.
  4. tick with turn_sec_left > 1 → decrement. If the new value equals WARN_SEC (WARN_SEC ≠ 0), sound code 5.
  5. tick with turn_sec_left == 1 → timeout pulse and sound code 3, then:
     - TIMEOUT_MODE 0: advance player and reload; stay in PLAY.
     - TIMEOUT_MODE 1: → SETTLE; winner = (current_player+1) mod N_PLAYERS.
- A lower-priority event coinciding with a higher one is discarded, not deferred. A tick coinciding with move_done is consumed by the reload.
- PAUSE:
  - key_pause → PLAY; resume with preserved current_player, turn_sec_left and prescaler.
  - Otherwise key_confirm → MENU (abort).
  - key_pause wins if both arrive together.
  - move_done and game_over are ignored.
- SETTLE:
  - key_confirm → MENU.
  - winner holds until the next MENU→PLAY; the other inputs are ignored.
- Inputs in states that do not list them are ignored. turn_sec_left never reaches 0 visibly; it reloads on the same edge it would decrement to 0.

## Timing
- All outputs are registered.
- A pulse sampled on edge k produces its state, counter and sound change after edge k; visible in cycle k+1.
- board_clear, timeout and sound_req are exactly one cycle wide. sound_code is updated on the same edge as sound_req.
- At most one sound request per cycle; the highest-priority event supplies the code.
- The first decrement occurs CLK_HZ cycles after a reload; later decrements follow every CLK_HZ cycles of PLAY time, excluding PAUSE time.
- Asynchronous reset mid-turn or mid-pause returns every output to its reset value immediately. Counting restarts only after a new key_confirm.

## Test plan
- Bench parameters: CLK_HZ = 10, TURN_SEC = 3, WARN_SEC = 2, N_PLAYERS = 3.
- **Start:** key_confirm in MENU → next cycle state = 01, board_clear = 1 for one cycle, sound_code = 1, turn_sec_left = 3.
- **Countdown and skip timeout (TIMEOUT_MODE 0):** idle in PLAY →
  - turn_sec_left goes 2 after 10 cycles, with a warning pulse of code 5;
  - 1 after 20 cycles;
  - after 30 cycles: timeout pulse, code 3, current_player = 1, turn_sec_left = 3.
- **Rotation wrap:** three move_done pulses → current_player goes 1, 2, 0, with code 2 each time. move_done coinciding with a tick → reload to 3, no decrement.
- **Pause:** key_pause at 5 cycles into a turn, hold 50 cycles, key_pause again → turn_sec_left unchanged during the pause; the decrement occurs 5 PLAY cycles after resume. key_pause and key_confirm together in PAUSE → PLAY.
- **Forfeit (TIMEOUT_MODE 1):** player 2 times out → state = 11, winner = 0. Separately, game_over with move_done and winner_in = 1 → SETTLE, winner = 1, code 4. key_confirm → MENU.
- **Reset:** assert rstn low mid-PAUSE → state = 00, current_player = 0, turn_sec_left = 3, all pulses 0, without waiting for a clock edge.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game-flow controller and its neighbours
// (keyboard/selector pulses in, play/GFX/MUSIC status out).
interface game_flow_ctrl_if #(
  parameter int unsigned PW = 1
);
  logic          key_confirm;
  logic          key_pause;
  logic          move_done;
  logic          game_over;
  logic [PW-1:0] winner_in;

  logic [1:0]    state;
  logic [PW-1:0] current_player;
  logic [7:0]    turn_sec_left;
  logic [PW-1:0] winner;
  logic          board_clear;
  logic          timeout;
  logic          sound_req;
  logic [2:0]    sound_code;

  modport master (
    output key_confirm, key_pause, move_done, game_over, winner_in,
    input  state, current_player, turn_sec_left, winner,
           board_clear, timeout, sound_req, sound_code
  );

  modport slave (
    input  key_confirm, key_pause, move_done, game_over, winner_in,
    output state, current_player, turn_sec_left, winner,
           board_clear, timeout, sound_req, sound_code
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: MENU/PLAY/PAUSE/SETTLE with N-player turn rotation,
// a per-turn seconds countdown with timeout policy, and sound-event requests.
module game_flow_ctrl #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned N_PLAYERS    = 2,
  parameter int unsigned TURN_SEC     = 30,
  parameter int unsigned WARN_SEC     = 5,
  parameter int unsigned TIMEOUT_MODE = 0
) (
  input  logic clk,
  input  logic rstn,
  game_flow_ctrl_if.slave gf
);

  localparam int unsigned PW  = ($clog2(N_PLAYERS) < 1) ? 1 : $clog2(N_PLAYERS);
  localparam int unsigned PSW = ($clog2(CLK_HZ) < 1) ? 1 : $clog2(CLK_HZ);

  localparam logic [1:0] S_MENU   = 2'b00;
  localparam logic [1:0] S_PLAY   = 2'b01;
  localparam logic [1:0] S_PAUSE  = 2'b10;
  localparam logic [1:0] S_SETTLE = 2'b11;

  localparam logic [2:0] SND_START   = 3'd1;
  localparam logic [2:0] SND_MOVE    = 3'd2;
  localparam logic [2:0] SND_TIMEOUT = 3'd3;
  localparam logic [2:0] SND_END     = 3'd4;
  localparam logic [2:0] SND_WARN    = 3'd5;

  localparam logic [PSW-1:0] PRESC_LAST  = PSW'(CLK_HZ - 1);
  localparam logic [PSW-1:0] PRESC_ONE   = PSW'(1);
  localparam logic [PW-1:0]  LAST_PLAYER = PW'(N_PLAYERS - 1);
  localparam logic [PW-1:0]  PLAYER_ONE  = PW'(1);
  localparam logic [7:0]     TURN_V      = 8'(TURN_SEC);
  localparam logic [7:0]     WARN_V      = 8'(WARN_SEC);
  localparam bit             WARN_EN     = (WARN_SEC != 0);
  localparam bit             FORFEIT     = (TIMEOUT_MODE == 1);

  logic [1:0]     state_q,  state_d;
  logic [PW-1:0]  player_q, player_d;
  logic [7:0]     sec_q,    sec_d;
  logic [PW-1:0]  winner_q, winner_d;
  logic [PSW-1:0] presc_q,  presc_d;
  logic           bclr_q,   bclr_d;
  logic           tmo_q,    tmo_d;
  logic           sreq_q,   sreq_d;
  logic [2:0]     scode_q,  scode_d;

  logic [PW-1:0]  next_player;
  logic [7:0]     sec_dec;
  logic           tick;

  always_comb begin
    next_player = (player_q == LAST_PLAYER) ? '0 : player_q + PLAYER_ONE;
    sec_dec     = sec_q - 8'd1;
    tick        = (presc_q == PRESC_LAST);
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    sec_d    = sec_q;
    winner_d = winner_q;
    presc_d  = presc_q;
    scode_d  = scode_q;
    bclr_d   = 1'b0;
    tmo_d    = 1'b0;
    sreq_d   = 1'b0;

    case (state_q)
      S_MENU: begin
        if (gf.key_confirm) begin
          state_d  = S_PLAY;
          player_d = '0;
          sec_d    = TURN_V;
          presc_d  = '0;
          winner_d = '0;
          bclr_d   = 1'b1;
          sreq_d   = 1'b1;
          scode_d  = SND_START;
        end
      end

      // Strict priority chain: lower events in the same cycle are dropped.
      S_PLAY: begin
        if (gf.game_over) begin
          state_d  = S_SETTLE;
          winner_d = gf.winner_in;
          sreq_d   = 1'b1;
          scode_d  = SND_END;
        end else if (gf.key_pause) begin
          state_d = S_PAUSE;
        end else if (gf.move_done) begin
          player_d = next_player;
          sec_d    = TURN_V;
          presc_d  = '0;
          sreq_d   = 1'b1;
          scode_d  = SND_MOVE;
        end else if (tick) begin
          presc_d = '0;
          if (sec_q > 8'd1) begin
            sec_d = sec_dec;
            if (WARN_EN && (sec_dec == WARN_V)) begin
              sreq_d  = 1'b1;
              scode_d = SND_WARN;
            end
          end else begin
            // Last second expired: reload instead of showing 0.
            tmo_d   = 1'b1;
            sreq_d  = 1'b1;
            scode_d = SND_TIMEOUT;
            if (FORFEIT) begin
              state_d  = S_SETTLE;
              winner_d = next_player;
            end else begin
              player_d = next_player;
              sec_d    = TURN_V;
            end
          end
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end

      S_PAUSE: begin
        if (gf.key_pause) begin
          state_d = S_PLAY;
        end else if (gf.key_confirm) begin
          state_d = S_MENU;
        end
      end

      S_SETTLE: begin
        if (gf.key_confirm) begin
          state_d = S_MENU;
        end
      end

      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_MENU;
      player_q <= '0;
      sec_q    <= TURN_V;
      winner_q <= '0;
      presc_q  <= '0;
      bclr_q   <= 1'b0;
      tmo_q    <= 1'b0;
      sreq_q   <= 1'b0;
      scode_q  <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      sec_q    <= sec_d;
      winner_q <= winner_d;
      presc_q  <= presc_d;
      bclr_q   <= bclr_d;
      tmo_q    <= tmo_d;
      sreq_q   <= sreq_d;
      scode_q  <= scode_d;
    end
  end

  assign gf.state          = state_q;
  assign gf.current_player = player_q;
  assign gf.turn_sec_left  = sec_q;
  assign gf.winner         = winner_q;
  assign gf.board_clear    = bclr_q;
  assign gf.timeout        = tmo_q;
  assign gf.sound_req      = sreq_q;
  assign gf.sound_code     = scode_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: one instance per timeout policy,
// sound codes checked through per-instance expectation queues.
module tb_game_flow_ctrl;

  localparam int unsigned PW = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.PW(PW)) b0 ();
  game_flow_ctrl_if #(.PW(PW)) b1 ();

  game_flow_ctrl #(
    .CLK_HZ(10), .N_PLAYERS(3), .TURN_SEC(3), .WARN_SEC(2), .TIMEOUT_MODE(0)
  ) dut0 (
    .clk(clk), .rstn(rstn), .gf(b0.slave)
  );

  game_flow_ctrl #(
    .CLK_HZ(10), .N_PLAYERS(3), .TURN_SEC(3), .WARN_SEC(2), .TIMEOUT_MODE(1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .gf(b1.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  logic [1:0]    o_st;
  logic [PW-1:0] o_pl, o_win;
  logic [7:0]    o_sec;
  logic          o_bc, o_tmo, o_sr;
  logic [2:0]    o_sc;

  // Each sound request pops the code expected when the stimulus was driven.
  always @(negedge clk) begin : mon0
    logic [2:0] e;
    if (rstn === 1'b1 && b0.sound_req === 1'b1) begin
      if (q0.size() > 0) e = q0.pop_front();
      else               e = 3'bxxx;
      checks++;
      assert (b0.sound_code === e) else begin
        errors++;
        $error("FAIL snd0: got %0d expected %0d", b0.sound_code, e);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [2:0] e;
    if (rstn === 1'b1 && b1.sound_req === 1'b1) begin
      if (q1.size() > 0) e = q1.pop_front();
      else               e = 3'bxxx;
      checks++;
      assert (b1.sound_code === e) else begin
        errors++;
        $error("FAIL snd1: got %0d expected %0d", b1.sound_code, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic look(input bit d1);
    if (d1) begin
      o_st = b1.state; o_pl = b1.current_player; o_sec = b1.turn_sec_left;
      o_win = b1.winner; o_bc = b1.board_clear; o_tmo = b1.timeout;
      o_sr = b1.sound_req; o_sc = b1.sound_code;
    end else begin
      o_st = b0.state; o_pl = b0.current_player; o_sec = b0.turn_sec_left;
      o_win = b0.winner; o_bc = b0.board_clear; o_tmo = b0.timeout;
      o_sr = b0.sound_req; o_sc = b0.sound_code;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_core(input string tag, input bit d1, input logic [1:0] st,
                          input logic [PW-1:0] pl, input logic [7:0] sec);
    look(d1);
    chk({tag, ".state"}, 8'(o_st), 8'(st));
    chk({tag, ".player"}, 8'(o_pl), 8'(pl));
    chk({tag, ".sec"}, o_sec, sec);
  endtask

  task automatic chk_pulse(input string tag, input bit d1, input logic bc,
                           input logic tmo, input logic sr);
    look(d1);
    chk({tag, ".board_clear"}, 8'(o_bc), 8'(bc));
    chk({tag, ".timeout"}, 8'(o_tmo), 8'(tmo));
    chk({tag, ".sound_req"}, 8'(o_sr), 8'(sr));
  endtask

  task automatic mv0();
    b0.move_done = 1'b1; q0.push_back(3'd2); cyc(); b0.move_done = 1'b0;
  endtask

  task automatic mv1();
    b1.move_done = 1'b1; q1.push_back(3'd2); cyc(); b1.move_done = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    b0.key_confirm = 1'b0; b0.key_pause = 1'b0; b0.move_done = 1'b0;
    b0.game_over = 1'b0; b0.winner_in = '0;
    b1.key_confirm = 1'b0; b1.key_pause = 1'b0; b1.move_done = 1'b0;
    b1.game_over = 1'b0; b1.winner_in = '0;
    rstn = 1'b0;
    #12;
    chk_core("reset", 1'b0, 2'd0, 2'd0, 8'd3);
    chk_pulse("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.code", 8'(o_sc), 8'd0);
    chk("reset.winner", 8'(o_win), 8'd0);
    @(negedge clk); rstn = 1'b1;
    cyc();

    // Start: reload edge E0
    b0.key_confirm = 1'b1; q0.push_back(3'd1); cyc(); b0.key_confirm = 1'b0;
    chk_core("start", 1'b0, 2'd1, 2'd0, 8'd3);
    chk_pulse("start", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_pulse("start+1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Countdown: decrements at E10, E20, timeout at E30
    cycles(8);
    chk_core("pre_tick1", 1'b0, 2'd1, 2'd0, 8'd3);
    q0.push_back(3'd5); cyc();
    chk_core("tick1", 1'b0, 2'd1, 2'd0, 8'd2);
    chk_pulse("tick1", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    look(1'b0);
    chk("code_hold", 8'(o_sc), 8'd5);
    chk("tick1+1.sound_req", 8'(o_sr), 8'd0);
    cycles(8);
    chk_core("pre_tick2", 1'b0, 2'd1, 2'd0, 8'd2);
    cyc();
    chk_core("tick2", 1'b0, 2'd1, 2'd0, 8'd1);
    chk_pulse("tick2", 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(9);
    chk_core("pre_tmo", 1'b0, 2'd1, 2'd0, 8'd1);
    q0.push_back(3'd3); cyc();
    chk_core("tmo_skip", 1'b0, 2'd1, 2'd1, 8'd3);
    chk_pulse("tmo_skip", 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    chk_pulse("tmo_skip+1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Rotation with wrap
    mv0(); chk_core("rot1", 1'b0, 2'd1, 2'd2, 8'd3);
    mv0(); chk_core("rot_wrap", 1'b0, 2'd1, 2'd0, 8'd3);
    mv0(); chk_core("rot3", 1'b0, 2'd1, 2'd1, 8'd3);

    // move_done on the tick edge: reload wins, prescaler restarts
    cycles(9);
    mv0(); chk_core("move_on_tick", 1'b0, 2'd1, 2'd2, 8'd3);
    cycles(9);
    chk_core("reload_presc", 1'b0, 2'd1, 2'd2, 8'd3);
    q0.push_back(3'd5); cyc();
    chk_core("reload_tick", 1'b0, 2'd1, 2'd2, 8'd2);

    // Pause 5 cycles into a fresh turn
    mv0(); chk_core("pre_pause", 1'b0, 2'd1, 2'd0, 8'd3);
    cycles(5);
    b0.key_pause = 1'b1; cyc(); b0.key_pause = 1'b0;
    chk_core("pause", 1'b0, 2'd2, 2'd0, 8'd3);
    cycles(20);
    b0.move_done = 1'b1; b0.game_over = 1'b1; b0.winner_in = 2'd1;
    cyc();
    b0.move_done = 1'b0; b0.game_over = 1'b0; b0.winner_in = '0;
    chk_core("pause_ign", 1'b0, 2'd2, 2'd0, 8'd3);
    chk_pulse("pause_ign", 1'b0, 1'b0, 1'b0, 1'b0);
    cycles(29);
    chk_core("pause_hold", 1'b0, 2'd2, 2'd0, 8'd3);
    b0.key_pause = 1'b1; cyc(); b0.key_pause = 1'b0;
    chk_core("resume", 1'b0, 2'd1, 2'd0, 8'd3);
    cycles(4);
    chk_core("resume+4", 1'b0, 2'd1, 2'd0, 8'd3);
    q0.push_back(3'd5); cyc();
    chk_core("resume+5", 1'b0, 2'd1, 2'd0, 8'd2);

    // key_pause beats key_confirm in PAUSE; confirm alone aborts
    b0.key_pause = 1'b1; cyc(); b0.key_pause = 1'b0;
    look(1'b0); chk("pause2.state", 8'(o_st), 8'd2);
    b0.key_pause = 1'b1; b0.key_confirm = 1'b1; cyc();
    b0.key_pause = 1'b0; b0.key_confirm = 1'b0;
    chk_core("pause_and_confirm", 1'b0, 2'd1, 2'd0, 8'd2);
    b0.key_pause = 1'b1; cyc(); b0.key_pause = 1'b0;
    b0.key_confirm = 1'b1; cyc(); b0.key_confirm = 1'b0;
    look(1'b0); chk("abort.state", 8'(o_st), 8'd0);

    // Asynchronous reset in the middle of PAUSE
    b0.key_confirm = 1'b1; q0.push_back(3'd1); cyc(); b0.key_confirm = 1'b0;
    mv0(); chk_core("pre_rst", 1'b0, 2'd1, 2'd1, 8'd3);
    b0.key_pause = 1'b1; cyc(); b0.key_pause = 1'b0;
    cycles(3);
    #2 rstn = 1'b0;
    #1;
    chk_core("rst_async", 1'b0, 2'd0, 2'd0, 8'd3);
    chk_pulse("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_async.code", 8'(o_sc), 8'd0);
    @(negedge clk); rstn = 1'b1;
    cyc();

    // Forfeit policy: player 2 times out, winner wraps to 0
    b1.key_confirm = 1'b1; q1.push_back(3'd1); cyc(); b1.key_confirm = 1'b0;
    mv1(); mv1();
    chk_core("f_p2", 1'b1, 2'd1, 2'd2, 8'd3);
    cycles(9);
    q1.push_back(3'd5); cyc();
    chk_core("f_tick1", 1'b1, 2'd1, 2'd2, 8'd2);
    cycles(10);
    chk_core("f_tick2", 1'b1, 2'd1, 2'd2, 8'd1);
    cycles(9);
    q1.push_back(3'd3); cyc();
    look(1'b1);
    chk("forfeit.state", 8'(o_st), 8'd3);
    chk("forfeit.winner", 8'(o_win), 8'd0);
    chk("forfeit.timeout", 8'(o_tmo), 8'd1);
    b1.move_done = 1'b1; cyc(); b1.move_done = 1'b0;
    look(1'b1);
    chk("settle_ign.state", 8'(o_st), 8'd3);
    chk("settle_ign.player", 8'(o_pl), 8'd2);
    b1.key_confirm = 1'b1; cyc(); b1.key_confirm = 1'b0;
    look(1'b1);
    chk("f_menu.state", 8'(o_st), 8'd0);
    chk("f_menu.winner", 8'(o_win), 8'd0);

    // game_over beats a coincident move_done
    b1.key_confirm = 1'b1; q1.push_back(3'd1); cyc(); b1.key_confirm = 1'b0;
    b1.game_over = 1'b1; b1.move_done = 1'b1; b1.winner_in = 2'd1;
    q1.push_back(3'd4); cyc();
    b1.game_over = 1'b0; b1.move_done = 1'b0; b1.winner_in = '0;
    look(1'b1);
    chk("gover.state", 8'(o_st), 8'd3);
    chk("gover.winner", 8'(o_win), 8'd1);
    chk("gover.player", 8'(o_pl), 8'd0);
    b1.key_confirm = 1'b1; cyc(); b1.key_confirm = 1'b0;
    look(1'b1);
    chk("g_menu.state", 8'(o_st), 8'd0);
    chk("g_menu.winner", 8'(o_win), 8'd1);

    cycles(2);
    chk("q0_drained", 8'(q0.size()), 8'd0);
    chk("q1_drained", 8'(q1.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
